multicycle_control: RTL
=======================

Name: multicycle_control

Overview:
- Finite-state control unit for the multicycle MIPS datapath. It replaces the single-cycle opcode decoder.
- Sequences fetch, decode, execute, memory and writeback over several cycles, and stalls on a memory-ready handshake.
- Flags illegal opcodes and counts retired instructions.
- Sits between the instruction register (OP, Funct fields), the ALU Zero flag, the unified memory, and the datapath muxes and enables.

Parameters:
- ALUOP_WIDTH, 3, width of ALUOp. Codes are zero-extended to this width.
- CNT_WIDTH, 32, width of the retired-instruction counter.
- USE_MEM_READY, 1, 1 = honour mem_ready; 0 = treat mem_ready as constant 1.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- OP  input  6  opcode from instruction register
- Funct  input  6  function field from instruction register
- Zero  input  1  ALU zero flag
- mem_ready  input  1  memory access completes this cycle
- PCEn  output  1  PC register load enable
- IorD  output  1  memory address select: 0 = PC, 1 = ALUOut
- MemRead  output  1  memory read strobe
- MemWrite  output  1  memory write strobe
- IRWrite  output  1  instruction register load
- RegDst  output  2  write register select: 00 = rt, 01 = rd, 10 = r31
- MemtoReg  output  2  writeback source: 00 = ALUOut, 01 = MDR, 10 = PC
- RegWrite  output  1  register file write enable
- ALUSrcA  output  1  0 = PC, 1 = rs
- ALUSrcB  output  2  00 = rt, 01 = const 4, 10 = signext imm, 11 = signext imm<<2
- PCSource  output  2  00 = ALU result, 01 = ALUOut, 10 = jump target, 11 = rs
- ALUOp  output  ALUOP_WIDTH  ALU operation code
- Illegal  output  1  one-cycle pulse, unsupported opcode decoded
- State  output  4  current state (debug)
- InstrCount  output  CNT_WIDTH  retired instructions

Behaviour:
- Reset (async, while high):
  - State = FETCH (0); InstrCount = 0.
  - All enables/strobes (PCEn, IRWrite, MemRead, MemWrite, RegWrite) = 0.
  - All selects = 0; ALUOp = 0; Illegal = 0.
  - Deassertion mid-instruction restarts at FETCH; no partial writes are completed.
- ALUOp codes: ADD = 011, SUB = 001, R-type = 111, ADDI = 100, ORI = 101, ANDI = 010, LUI = 110.
- Opcodes: R = 00 (JR when Funct = 08), ADDI = 08, ANDI = 0c, ORI = 0d, LUI = 0f, LW = 23, SW = 2b, BEQ = 04, BNE = 05, J = 02, JAL = 03.
- Outputs are a Moore decode of State. Exceptions: PCEn/IRWrite are gated by mem_ready in FETCH, and PCEn by Zero in BRANCH.
- State encodings and actions; unlisted outputs = 0:
  - FETCH (0): MemRead = 1, ALUSrcB = 01, ALUOp = ADD. IRWrite = PCEn = mem_ready. Stay while !mem_ready, else go to DECODE.
  - DECODE (1): ALUSrcB = 11, ALUOp = ADD (branch target into ALUOut). Next state:
    - LW/SW: MEMADR.
    - R with Funct = 08: JR. Other R: RTEX.
    - BEQ/BNE: BRANCH.
    - ADDI/ANDI/ORI/LUI: IEX.
    - J: JUMP. JAL: JAL.
    - Otherwise: Illegal = 1, go to FETCH.
  - MEMADR (2): ALUSrcA = 1, ALUSrcB = 10, ALUOp = ADD. Go to MEMRD (LW) or MEMWR (SW).
  - MEMRD (3): IorD = 1, MemRead = 1. Hold until mem_ready, then go to MEMWB.
  - MEMWB (4): RegDst = 00, MemtoReg = 01, RegWrite = 1. Go to FETCH.
  - MEMWR (5): IorD = 1, MemWrite = 1. Held until mem_ready, then go to FETCH.
  - RTEX (6): ALUSrcA = 1, ALUSrcB = 00, ALUOp = 111. Go to ALUWB.
  - ALUWB (7): RegDst = 01, RegWrite = 1. Go to FETCH.
  - BRANCH (8): ALUSrcA = 1, ALUOp = SUB, PCSource = 01. PCEn = (BEQ & Zero) | (BNE & !Zero). Go to FETCH.
  - JUMP (9): PCSource = 10, PCEn = 1. Go to FETCH.
  - IEX (10): ALUSrcA = 1, ALUSrcB = 10, ALUOp per opcode. Go to IWB.
  - IWB (11): RegDst = 00, RegWrite = 1. Go to FETCH.
  - JR (12): PCSource = 11, PCEn = 1. Go to FETCH.
  - JAL (13): PCSource = 10, PCEn = 1, RegDst = 10, MemtoReg = 10, RegWrite = 1. PC already holds PC+4. Go to FETCH.
  - Codes 14-15: unreachable; treat as FETCH next cycle.
- OP/Funct are sampled only in DECODE; changes in other states are ignored.
- InstrCount:
  - Increments by 1 on every transition into FETCH from MEMWB, MEMWR, ALUWB, BRANCH, JUMP, IWB, JR or JAL.
  - Does not increment on the illegal path or on FETCH self-loops.
  - Wraps modulo 2^CNT_WIDTH.
- Latency with mem_ready constantly 1, in cycles: R-type 4, LW 5, SW 4, ADDI/ORI/ANDI/LUI 4, BEQ/BNE 3, J/JR/JAL 3.

Test Plan:
- Reset asserted mid-MEMRD, released -> State = 0, InstrCount = 0, RegWrite = 0 throughout; next cycle FETCH with MemRead = 1.
- ADD (OP = 00, Funct = 20), mem_ready = 1 -> states 0,1,6,7,0; RegWrite = 1 with RegDst = 01 only in state 7; InstrCount 0 -> 1.
- LW with mem_ready low 3 cycles in MEMRD -> state 3 held 4 cycles, MemRead = IorD = 1 throughout; MEMWB asserts MemtoReg = 01, RegWrite = 1; total 8 cycles.
- BEQ with Zero = 1, then BNE with Zero = 1 -> BEQ: PCEn = 1, PCSource = 01 in state 8. BNE: PCEn = 0. InstrCount +2.
- JAL (OP = 03) -> state 13: PCEn = 1, RegDst = 10, MemtoReg = 10, RegWrite = 1; JR (OP = 00, Funct = 08) -> state 12, PCSource = 11.
- OP = 3f -> Illegal pulses 1 cycle in DECODE, returns to FETCH, InstrCount unchanged. CNT_WIDTH = 4 with 16 retired instructions -> InstrCount wraps to 0.

Source files
------------

// File: rtl/multicycle_control.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback,
// stalls on mem_ready, flags illegal opcodes and counts retired instructions.
module multicycle_control #(
    parameter int ALUOP_WIDTH   = 3,
    parameter int CNT_WIDTH     = 32,
    parameter bit USE_MEM_READY = 1'b1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [5:0]             OP,
    input  logic [5:0]             Funct,
    input  logic                   Zero,
    input  logic                   mem_ready,
    output logic                   PCEn,
    output logic                   IorD,
    output logic                   MemRead,
    output logic                   MemWrite,
    output logic                   IRWrite,
    output logic [1:0]             RegDst,
    output logic [1:0]             MemtoReg,
    output logic                   RegWrite,
    output logic                   ALUSrcA,
    output logic [1:0]             ALUSrcB,
    output logic [1:0]             PCSource,
    output logic [ALUOP_WIDTH-1:0] ALUOp,
    output logic                   Illegal,
    output logic [3:0]             State,
    output logic [CNT_WIDTH-1:0]   InstrCount
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD = 4'd3,
        S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_RTEX   = 4'd6,  S_ALUWB = 4'd7,
        S_BRANCH = 4'd8,  S_JUMP   = 4'd9,  S_IEX    = 4'd10, S_IWB   = 4'd11,
        S_JR     = 4'd12, S_JAL    = 4'd13
    } state_t;

    localparam logic [5:0] OP_R    = 6'h00, OP_J    = 6'h02, OP_JAL  = 6'h03;
    localparam logic [5:0] OP_BEQ  = 6'h04, OP_BNE  = 6'h05, OP_ADDI = 6'h08;
    localparam logic [5:0] OP_ANDI = 6'h0c, OP_ORI  = 6'h0d, OP_LUI  = 6'h0f;
    localparam logic [5:0] OP_LW   = 6'h23, OP_SW   = 6'h2b, FN_JR   = 6'h08;

    localparam logic [2:0] ALU_ADD = 3'b011, ALU_SUB = 3'b001, ALU_RT   = 3'b111;
    localparam logic [2:0] ALU_ADDI = 3'b100, ALU_ORI = 3'b101, ALU_ANDI = 3'b010;
    localparam logic [2:0] ALU_LUI = 3'b110, ALU_NONE = 3'b000;

    state_t               state_q, state_d;
    logic [5:0]           op_q, op_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 rdy_s, retire_s, illegal_s;

    logic       pcen_s, iord_s, memread_s, memwrite_s, irwrite_s, regwrite_s, srca_s;
    logic [1:0] regdst_s, memtoreg_s, srcb_s, pcsrc_s;
    logic [2:0] aluop_s;

    assign rdy_s = USE_MEM_READY ? mem_ready : 1'b1;

    // Next-state, opcode latch (only in DECODE) and retirement detection
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        retire_s  = 1'b0;
        illegal_s = 1'b0;
        case (state_q)
            S_FETCH:  state_d = rdy_s ? S_DECODE : S_FETCH;
            S_DECODE: begin
                op_d = OP;
                case (OP)
                    OP_LW, OP_SW:                     state_d = S_MEMADR;
                    OP_R:                             state_d = (Funct == FN_JR) ? S_JR : S_RTEX;
                    OP_BEQ, OP_BNE:                   state_d = S_BRANCH;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_LUI: state_d = S_IEX;
                    OP_J:                             state_d = S_JUMP;
                    OP_JAL:                           state_d = S_JAL;
                    default: begin
                        illegal_s = 1'b1;
                        state_d   = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: state_d = (op_q == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  state_d = rdy_s ? S_MEMWB : S_MEMRD;
            S_MEMWR: begin
                state_d  = rdy_s ? S_FETCH : S_MEMWR;
                retire_s = rdy_s;
            end
            S_RTEX:   state_d = S_ALUWB;
            S_IEX:    state_d = S_IWB;
            S_MEMWB, S_ALUWB, S_BRANCH, S_JUMP, S_IWB, S_JR, S_JAL: begin
                state_d  = S_FETCH;
                retire_s = 1'b1;
            end
            default:  state_d = S_FETCH;
        endcase
        cnt_d = cnt_q + CNT_WIDTH'(retire_s);
    end

    // State, latched opcode and retired-instruction counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
            op_q    <= 6'h00;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
        end
    end

    // Moore decode of the current state; FETCH and BRANCH gate PCEn on inputs
    always_comb begin
        pcen_s = 1'b0; iord_s = 1'b0; memread_s = 1'b0; memwrite_s = 1'b0;
        irwrite_s = 1'b0; regwrite_s = 1'b0; srca_s = 1'b0;
        regdst_s = 2'b00; memtoreg_s = 2'b00; srcb_s = 2'b00; pcsrc_s = 2'b00;
        aluop_s = ALU_NONE;
        case (state_q)
            S_FETCH: begin
                memread_s = 1'b1; srcb_s = 2'b01; aluop_s = ALU_ADD;
                irwrite_s = rdy_s; pcen_s = rdy_s;
            end
            S_DECODE: begin srcb_s = 2'b11; aluop_s = ALU_ADD; end
            S_MEMADR: begin srca_s = 1'b1; srcb_s = 2'b10; aluop_s = ALU_ADD; end
            S_MEMRD:  begin iord_s = 1'b1; memread_s = 1'b1; end
            S_MEMWB:  begin memtoreg_s = 2'b01; regwrite_s = 1'b1; end
            S_MEMWR:  begin iord_s = 1'b1; memwrite_s = 1'b1; end
            S_RTEX:   begin srca_s = 1'b1; aluop_s = ALU_RT; end
            S_ALUWB:  begin regdst_s = 2'b01; regwrite_s = 1'b1; end
            S_BRANCH: begin
                srca_s = 1'b1; aluop_s = ALU_SUB; pcsrc_s = 2'b01;
                pcen_s = ((op_q == OP_BEQ) & Zero) | ((op_q == OP_BNE) & ~Zero);
            end
            S_JUMP:   begin pcsrc_s = 2'b10; pcen_s = 1'b1; end
            S_IEX: begin
                srca_s = 1'b1; srcb_s = 2'b10;
                case (op_q)
                    OP_ADDI: aluop_s = ALU_ADDI;
                    OP_ANDI: aluop_s = ALU_ANDI;
                    OP_ORI:  aluop_s = ALU_ORI;
                    OP_LUI:  aluop_s = ALU_LUI;
                    default: aluop_s = ALU_NONE;
                endcase
            end
            S_IWB:    regwrite_s = 1'b1;
            S_JR:     begin pcsrc_s = 2'b11; pcen_s = 1'b1; end
            S_JAL: begin
                pcsrc_s = 2'b10; pcen_s = 1'b1; regdst_s = 2'b10;
                memtoreg_s = 2'b10; regwrite_s = 1'b1;
            end
            default: aluop_s = ALU_NONE;
        endcase
    end

    // Everything is held at zero while reset is high, including FETCH's strobes
    assign PCEn       = pcen_s & ~reset;
    assign IorD       = iord_s & ~reset;
    assign MemRead    = memread_s & ~reset;
    assign MemWrite   = memwrite_s & ~reset;
    assign IRWrite    = irwrite_s & ~reset;
    assign RegWrite   = regwrite_s & ~reset;
    assign ALUSrcA    = srca_s & ~reset;
    assign RegDst     = regdst_s & {2{~reset}};
    assign MemtoReg   = memtoreg_s & {2{~reset}};
    assign ALUSrcB    = srcb_s & {2{~reset}};
    assign PCSource   = pcsrc_s & {2{~reset}};
    assign ALUOp      = ALUOP_WIDTH'(aluop_s & {3{~reset}});
    assign Illegal    = illegal_s & ~reset;
    assign State      = state_q;
    assign InstrCount = cnt_q;

endmodule
